vram_scan_arbiter: RTL

- Shares one single-port frame-buffer RAM between two requesters: the display scanout prefetcher and the game-logic pixel writer.
- Scanout reads are fetched ahead in raster order into a small pixel FIFO. The VGA pixel path pops that FIFO once per active pixel.
- Writer requests are served in slots where the FIFO has enough margin.
- Sits between the VGA sync/colour path and the frame-buffer RAM, in the vga_clk domain.

---
 rtl/vram_scan_arbiter_if.sv | 30 +++
 rtl/vram_scan_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vram_scan_arbiter_if.sv
// Bundle of the pixel-pop, writer-handshake and frame-buffer RAM signals.
// master: the arbiter side; slave: display path, writer and RAM.
interface vram_scan_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic              frame_start;
  logic              pix_pop;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              underflow;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  frame_start, pix_pop, wr_req, wr_addr, wr_data, mem_rdata,
    output pix_data, pix_valid, underflow, wr_ack, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output frame_start, pix_pop, wr_req, wr_addr, wr_data, mem_rdata,
    input  pix_data, pix_valid, underflow, wr_ack, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Single-port frame-buffer arbiter: raster-order scanout prefetch FIFO vs. pixel writer.
// Optional writer starvation guard: define VRAM_WR_STARVE_GUARD_EN.
module vram_scan_arbiter #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 600,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 4,
  parameter int MAX_WAIT   = 32
) (
  input  logic                vga_clk,
  input  logic                rst,
  vram_scan_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [CNT_W:0]    LOW_OCC   = (CNT_W + 1)'(LOW_WM);
  localparam logic [CNT_W:0]    FULL_OCC  = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, FILL} slot_t;

  slot_t             w_slot;
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_inflight;
  logic              r_scan_en;
  logic              r_underflow;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [CNT_W:0]    w_occ;
  logic              w_scan_ok;
  logic              w_read;
  logic              w_write;
  logic              w_push;
  logic              w_pop;
  logic              w_force;

  assign w_occ     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  // No read is issued alongside frame_start: it would land after the flush.
  assign w_scan_ok = r_scan_en && !bus.frame_start;

`ifdef VRAM_WR_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] r_wait;

  assign w_force = bus.wr_req && (r_wait >= WAIT_W'(MAX_WAIT)) && (r_count != '0);

  always_ff @(posedge vga_clk) begin
    if (rst || !bus.wr_req || w_write) r_wait <= '0;
    else if (r_wait < WAIT_W'(MAX_WAIT)) r_wait <= r_wait + WAIT_W'(1);
  end
`else
  assign w_force = (MAX_WAIT < 0);  // guard compiled out: constant 0
`endif

  always_comb begin
    w_slot = IDLE;
    if (rst) w_slot = IDLE;
    else if (w_force) w_slot = WRITE;
    else if (w_scan_ok && (w_occ < LOW_OCC)) w_slot = SCAN;
    else if (bus.wr_req) w_slot = WRITE;
    else if (w_scan_ok && (w_occ < FULL_OCC)) w_slot = FILL;
  end

  assign w_read  = (w_slot == SCAN) || (w_slot == FILL);
  assign w_write = (w_slot == WRITE);
  assign w_push  = r_inflight;
  assign w_pop   = bus.pix_pop && (r_count != '0);

  assign bus.wr_ack    = w_write;
  assign bus.mem_we    = w_write;
  assign bus.pix_valid = (r_count != '0);
  assign bus.pix_data  = r_fifo[r_rd_ptr];
  assign bus.underflow = r_underflow;

  always_comb begin
    bus.mem_addr  = r_mem_addr;
    bus.mem_wdata = r_mem_wdata;
    if (w_read) begin
      bus.mem_addr = r_fetch_addr;
    end else if (w_write) begin
      bus.mem_addr  = bus.wr_addr;
      bus.mem_wdata = bus.wr_data;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_inflight   <= 1'b0;
      r_scan_en    <= 1'b0;
      r_underflow  <= 1'b0;
      r_fetch_addr <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_mem_addr  <= bus.mem_addr;
      r_mem_wdata <= bus.mem_wdata;
      if (bus.pix_pop && (r_count == '0)) r_underflow <= 1'b1;
      if (bus.frame_start) begin
        r_rd_ptr     <= '0;
        r_wr_ptr     <= '0;
        r_count      <= '0;
        r_inflight   <= 1'b0;
        r_fetch_addr <= '0;
        r_scan_en    <= 1'b1;
      end else begin
        r_inflight <= w_read;
        if (w_push) begin
          r_fifo[r_wr_ptr] <= bus.mem_rdata;
          r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push && !w_pop) r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        if (w_read) begin
          if (r_fetch_addr == LAST_ADDR) r_scan_en <= 1'b0;
          else r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
        end
      end
    end
  end
endmodule
